// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - multi-channel button synchroniser, debouncer and press/release/long/repeat event generator
// Optional feature macro: AUTOREPEAT_EN (auto-repeat pulses while a button stays held).
module button_conditioner #(
    parameter int   N_BTN      = 4,
    parameter logic ACT_LEVEL  = 1'b0,
    parameter int   DEB_CYC    = 50000,
    parameter int   LONG_CYC   = 1000000,
    parameter int   REPEAT_CYC = 250000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_BTN-1:0] btn_raw_i,
    output logic [N_BTN-1:0] btn_level_o,
    output logic [N_BTN-1:0] btn_press_o,
    output logic [N_BTN-1:0] btn_release_o,
    output logic [N_BTN-1:0] btn_long_o,
    output logic [N_BTN-1:0] btn_repeat_o
);

    localparam int DW = $clog2(DEB_CYC);
    localparam int LW = $clog2(LONG_CYC);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYC - 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYC - 1);

    if (DEB_CYC < 2 || LONG_CYC <= DEB_CYC || REPEAT_CYC < 2) begin : g_bad_cfg
        $error("button_conditioner: illegal timing parameters");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_HELD
    } state_e;

    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] level_q, level_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] release_q, release_d;
    logic [N_BTN-1:0] long_q, long_d;
    logic [N_BTN-1:0] pressed;
    logic [N_BTN-1:0] accept_press, accept_release;

    logic [DW-1:0] deb_cnt_q  [N_BTN];
    logic [DW-1:0] deb_cnt_d  [N_BTN];
    logic [LW-1:0] hold_cnt_q [N_BTN];
    logic [LW-1:0] hold_cnt_d [N_BTN];
    state_e        state_q    [N_BTN];
    state_e        state_d    [N_BTN];

`ifdef AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYC);
    localparam logic [RW-1:0] REP_MAX = RW'(REPEAT_CYC - 1);
    logic [RW-1:0]    rep_cnt_q [N_BTN];
    logic [RW-1:0]    rep_cnt_d [N_BTN];
    logic [N_BTN-1:0] repeat_q, repeat_d;
`endif

    // Polarity normalisation: 1 means pressed regardless of pin polarity.
    assign pressed = sync2_q ^ {N_BTN{~ACT_LEVEL}};

    always_comb begin
        level_d        = level_q;
        press_d        = '0;
        release_d      = '0;
        long_d         = '0;
        accept_press   = '0;
        accept_release = '0;
`ifdef AUTOREPEAT_EN
        repeat_d       = '0;
`endif
        for (int i = 0; i < N_BTN; i++) begin
            deb_cnt_d[i]  = deb_cnt_q[i];
            hold_cnt_d[i] = hold_cnt_q[i];
            state_d[i]    = state_q[i];
`ifdef AUTOREPEAT_EN
            rep_cnt_d[i]  = rep_cnt_q[i];
`endif
            // Any sample agreeing with the accepted level restarts the stability window.
            if (pressed[i] == level_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_MAX) begin
                deb_cnt_d[i]      = '0;
                level_d[i]        = pressed[i];
                accept_press[i]   = pressed[i];
                accept_release[i] = ~pressed[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end

            press_d[i]   = accept_press[i];
            release_d[i] = accept_release[i];

            case (state_q[i])
                ST_IDLE: begin
                    if (accept_press[i]) begin
                        state_d[i]    = ST_PRESSED;
                        hold_cnt_d[i] = '0;
                    end
                end
                ST_PRESSED: begin
                    if (accept_release[i]) begin
                        state_d[i]    = ST_IDLE;
                        hold_cnt_d[i] = '0;
                    end else if (hold_cnt_q[i] == LONG_MAX) begin
                        state_d[i]    = ST_HELD;
                        long_d[i]     = 1'b1;
`ifdef AUTOREPEAT_EN
                        rep_cnt_d[i]  = '0;
`endif
                    end else begin
                        hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (accept_release[i]) begin
                        state_d[i]    = ST_IDLE;
                        hold_cnt_d[i] = '0;
`ifdef AUTOREPEAT_EN
                        rep_cnt_d[i]  = '0;
                    end else if (rep_cnt_q[i] == REP_MAX) begin
                        rep_cnt_d[i]  = '0;
                        repeat_d[i]   = 1'b1;
                    end else begin
                        rep_cnt_d[i]  = rep_cnt_q[i] + 1'b1;
`endif
                    end
                end
                default: begin
                    state_d[i]    = ST_IDLE;
                    hold_cnt_d[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= {N_BTN{~ACT_LEVEL}};
            sync2_q   <= {N_BTN{~ACT_LEVEL}};
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                deb_cnt_q[i]  <= '0;
                hold_cnt_q[i] <= '0;
                state_q[i]    <= ST_IDLE;
            end
        end else begin
            sync1_q   <= btn_raw_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            for (int i = 0; i < N_BTN; i++) begin
                deb_cnt_q[i]  <= deb_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
                state_q[i]    <= state_d[i];
            end
        end
    end

`ifdef AUTOREPEAT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            repeat_q <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                rep_cnt_q[i] <= '0;
            end
        end else begin
            repeat_q <= repeat_d;
            for (int i = 0; i < N_BTN; i++) begin
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
        end
    end

    assign btn_repeat_o = repeat_q;
`else
    assign btn_repeat_o = '0;
`endif

    assign btn_level_o   = level_q;
    assign btn_press_o   = press_q;
    assign btn_release_o = release_q;
    assign btn_long_o    = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed self-checking bench for button_conditioner
module tb_button_conditioner;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw = '1;
    logic [N-1:0] level, press, release_p, long_p, rep;
    logic [N-1:0] ev;

    int errors = 0;
    int checks = 0;

    button_conditioner #(
        .N_BTN(N), .ACT_LEVEL(1'b0), .DEB_CYC(4), .LONG_CYC(20), .REPEAT_CYC(8)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .btn_raw_i(raw),
        .btn_level_o(level),
        .btn_press_o(press),
        .btn_release_o(release_p),
        .btn_long_o(long_p),
        .btn_repeat_o(rep)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset with all pins idle-high
        raw   = 4'hF;
        rst_n = 1'b0;
        tick(5);
        chk("rst_level", 32'(level), 0);
        chk("rst_events", 32'({press, release_p, long_p, rep}), 0);
        rst_n = 1'b1;
        ev = '0;
        for (int k = 0; k < 50; k++) begin
            tick(1);
            ev |= press | release_p | long_p | rep | level;
        end
        chk("idle_quiet", 32'(ev), 0);

        // 2: clean press then release on channel 0
        raw[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            chk($sformatf("t2_press_k%0d", k), 32'(press[0]), 32'(k == 6));
            chk($sformatf("t2_level_k%0d", k), 32'(level[0]), 32'(k >= 6));
        end
        raw[0] = 1'b1;
        for (int k = 11; k <= 20; k++) begin
            tick(1);
            chk($sformatf("t2_rel_k%0d", k), 32'(release_p[0]), 32'(k == 16));
            chk($sformatf("t2_lvl_k%0d", k), 32'(level[0]), 32'(k < 16));
            chk($sformatf("t2_prs_k%0d", k), 32'(press[0] | long_p[0]), 0);
        end

        // 3: 3-cycle glitch on channel 1 must be rejected
        raw[1] = 1'b0;
        tick(3);
        raw[1] = 1'b1;
        ev = '0;
        for (int k = 0; k < 12; k++) begin
            tick(1);
            ev |= press | level | release_p;
        end
        chk("t3_glitch", 32'(ev), 0);

        // 4: long hold on channel 2
        raw[2] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            chk($sformatf("t4_press_k%0d", k), 32'(press[2]), 32'(k == 6));
            chk($sformatf("t4_long_k%0d", k), 32'(long_p[2]), 32'(k == 26));
`ifdef AUTOREPEAT_EN
            chk($sformatf("t4_rep_k%0d", k), 32'(rep[2]), 32'(k == 34));
`else
            chk($sformatf("t4_rep_k%0d", k), 32'(rep[2]), 0);
`endif
        end
        raw[2] = 1'b1;
        for (int k = 41; k <= 50; k++) begin
            tick(1);
            chk($sformatf("t4_rel_k%0d", k), 32'(release_p[2]), 32'(k == 46));
            chk($sformatf("t4_nolong_k%0d", k), 32'(long_p[2] | press[2]), 0);
`ifdef AUTOREPEAT_EN
            chk($sformatf("t4_rep_k%0d", k), 32'(rep[2]), 32'(k == 42));
`else
            chk($sformatf("t4_rep_k%0d", k), 32'(rep[2]), 0);
`endif
        end
        tick(5);
        chk("t4_rep_quiet", 32'(rep), 0);

        // 5: all channels pressed in the same cycle
        raw = 4'h0;
        tick(5);
        chk("t5_pre", 32'(press), 0);
        tick(1);
        chk("t5_press", 32'(press), 32'hF);
        chk("t5_level", 32'(level), 32'hF);
        tick(1);
        chk("t5_post", 32'(press), 0);
        raw = 4'hF;
        tick(10);
        chk("t5_released", 32'(level), 0);

        // 6: reset in the middle of a hold
        raw[0] = 1'b0;
        tick(6);
        chk("t6_press0", 32'(press[0]), 1);
        tick(10);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_level", 32'(level), 0);
        chk("t6_rst_events", 32'({press, release_p, long_p, rep}), 0);
        tick(3);
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            chk($sformatf("t6_press_k%0d", k), 32'(press[0]), 32'(k == 6));
            chk($sformatf("t6_long_k%0d", k), 32'(long_p[0]), 32'(k == 26));
            chk($sformatf("t6_rel_k%0d", k), 32'(release_p[0]), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
